// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC, instruction-memory request
// handshake, one-entry skid buffer and the IF/ID pipeline register.
// Branch/jump targets are formed from the IF/ID contents and applied when
// the controller signals a redirect for the instruction held there.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        pc_src,
   input  logic        jump,
   output logic [31:0] pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic [5:0]  op_code,
   output logic [5:0]  funct
);

   // FETCH: request at pc. DISCARD: finish an abandoned request, drop its data.
   // HOLD: response parked in the skid while decode is stalled.
   typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_e;

   localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

   state_e      state_q, state_d;
   logic        run_q, run_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_plus4_q, skid_pc_plus4_d;

   logic        accept;
   logic        redir;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [31:0] redir_target;

   // Handshake, redirect decision and target arithmetic (all sums wrap mod 2^32)
   always_comb begin
      accept        = run_q & imem_ready;
      redir         = if_id_valid_q & ~stall & (jump | pc_src);
      pc_plus4      = pc_q + 32'd4;
      jump_target   = {if_id_pc_plus4_q[31:28], if_id_instr_q[25:0], 2'b00};
      branch_target = if_id_pc_plus4_q + {{14{if_id_instr_q[15]}}, if_id_instr_q[15:0], 2'b00};
      redir_target  = jump ? jump_target : branch_target;
   end

   // State register and all datapath flops; everything clears asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= FETCH;
         run_q            <= 1'b0;
         pc_q             <= RESET_ADDR;
         req_addr_q       <= RESET_ADDR;
         if_id_valid_q    <= 1'b0;
         if_id_instr_q    <= 32'h0;
         if_id_pc_plus4_q <= 32'h0;
         skid_instr_q     <= 32'h0;
         skid_pc_plus4_q  <= 32'h0;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values.
         state_q          <= state_d;
         run_q            <= run_d;
         pc_q             <= pc_d;
         req_addr_q       <= req_addr_d;
         if_id_valid_q    <= if_id_valid_d;
         if_id_instr_q    <= if_id_instr_d;
         if_id_pc_plus4_q <= if_id_pc_plus4_d;
         skid_instr_q     <= skid_instr_d;
         skid_pc_plus4_q  <= skid_pc_plus4_d;
      end
   end

   // Next-state logic for the fetch FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH: begin
            if (accept && stall)            state_d = HOLD;
            else if (!imem_ready && redir)  state_d = DISCARD;
         end
         DISCARD: begin
            if (imem_ready)                 state_d = FETCH;
         end
         HOLD: begin
            if (!stall)                     state_d = FETCH;
         end
         default:                           state_d = FETCH;
      endcase
   end

   // Datapath next values: PC, IF/ID register, skid buffer, request address
   always_comb begin
      // NOTE: every target gets a default first so no path infers a latch.
      run_d            = 1'b1;
      pc_d             = pc_q;
      if_id_valid_d    = if_id_valid_q;
      if_id_instr_d    = if_id_instr_q;
      if_id_pc_plus4_d = if_id_pc_plus4_q;
      skid_instr_d     = skid_instr_q;
      skid_pc_plus4_d  = skid_pc_plus4_q;

      if (redir) begin
         // Redirect flushes IF/ID; any data returned this cycle is dropped.
         pc_d             = redir_target;
         if_id_valid_d    = 1'b0;
         if_id_instr_d    = 32'h0;
         if_id_pc_plus4_d = 32'h0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (accept && stall) begin
                  skid_instr_d    = imem_rdata;
                  skid_pc_plus4_d = pc_plus4;
               end else if (accept) begin
                  if_id_valid_d    = 1'b1;
                  if_id_instr_d    = imem_rdata;
                  if_id_pc_plus4_d = pc_plus4;
                  pc_d             = pc_plus4;
               end else if (!stall) begin
                  // Decode consumed IF/ID and nothing arrived: insert a bubble.
                  if_id_valid_d    = 1'b0;
                  if_id_instr_d    = 32'h0;
                  if_id_pc_plus4_d = 32'h0;
               end
            end
            DISCARD: begin
               if (!stall) begin
                  if_id_valid_d    = 1'b0;
                  if_id_instr_d    = 32'h0;
                  if_id_pc_plus4_d = 32'h0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  if_id_valid_d    = 1'b1;
                  if_id_instr_d    = skid_instr_q;
                  if_id_pc_plus4_d = skid_pc_plus4_q;
                  pc_d             = skid_pc_plus4_q;
               end
            end
            default: ;
         endcase
      end

      // The abandoned address is held through DISCARD; otherwise it tracks pc.
      req_addr_d = (state_d == DISCARD) ? req_addr_q : pc_d;
   end

   // FSM outputs: request is idle while a response is parked in the skid
   always_comb begin
      imem_req = run_q & (state_q != HOLD);
   end

   assign imem_addr      = req_addr_q;
   assign pc             = pc_q;
   assign if_id_valid    = if_id_valid_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc_plus4 = if_id_pc_plus4_q;
   assign op_code        = if_id_instr_q[31:26];
   assign funct          = if_id_instr_q[5:0];

endmodule
